// File: rtl/synth_pkg.sv
// Shared constants for the polyphonic tone generator.
//   - wave_e     : per-unit waveform select codes
//   - DIV_*      : nominal sample-tick divisors for a 100 MHz control clock
//   - K_*        : phase-increment scale factors, round(2^32 / sample rate)
//   - PHASE_W    : phase accumulator width
package synth_pkg;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_OFF    = 2'd3
    } wave_e;

    localparam int PHASE_W = 32;
    localparam int CNT_W   = 12;
    localparam int K_W     = 17;

    localparam logic [CNT_W-1:0] DIV_48K  = 12'd2083;
    localparam logic [CNT_W-1:0] DIV_44K1 = 12'd2267;

    localparam logic [K_W-1:0] K_48K  = 17'd89478;
    localparam logic [K_W-1:0] K_44K1 = 17'd97392;

endpackage

// File: rtl/synth_osc.sv
// One oscillator unit: a 32-bit phase accumulator plus waveform shaper.
//   clk       : control clock, rising edge
//   rst       : synchronous reset, active-low; clears the phase
//   tick      : sample strobe; phase advances only on this cycle
//   freq      : unit frequency in Hz (unsigned)
//   k         : phase-increment scale for the selected sample rate
//   wave_type : waveform select (see synth_pkg::wave_e)
//   sample    : signed unit value, full scale +/- 2^FIXED_POINT,
//               derived from the current (pre-update) phase
module synth_osc
    import synth_pkg::*;
#(
    parameter int FIXED_POINT = 8,
    parameter int FREQ_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic [FREQ_WIDTH-1:0]         freq,
    input  logic [K_W-1:0]                k,
    input  logic [1:0]                    wave_type,
    output logic signed [FIXED_POINT+1:0] sample
);

    localparam int SW = FIXED_POINT + 2;

    logic [PHASE_W-1:0]      phase_q;
    logic [PHASE_W-1:0]      phase_d;
    logic [PHASE_W-1:0]      inc;
    logic [FIXED_POINT:0]    p;
    logic signed [SW-1:0]    p_s;
    logic signed [SW-1:0]    one_s;

    // Evaluated in a 32-bit context so the product wraps mod 2^32.
    assign inc     = PHASE_W'(freq) * PHASE_W'(k);
    assign phase_d = tick ? (phase_q + inc) : phase_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign p     = phase_q[PHASE_W-1 -: FIXED_POINT+1];
    assign p_s   = signed'({1'b0, p});
    assign one_s = SW'(1 << FIXED_POINT);

    always_comb begin
        sample = '0;
        case (wave_e'(wave_type))
            WAVE_SQUARE: sample = phase_q[PHASE_W-1] ? -one_s : one_s;
            WAVE_SAW:    sample = p_s - one_s;
            // Falling half written as (one-1) - 2(p-one), equal to
            // 3*one-1-2p, so every intermediate fits in FIXED_POINT+2 bits.
            WAVE_TRI:    sample = (p_s < one_s) ? ((p_s <<< 1) - one_s)
                                                : ((one_s - SW'(1)) - ((p_s - one_s) <<< 1));
            default:     sample = '0;
        endcase
    end

endmodule

// File: rtl/synth.sv
// Polyphonic tone generator top: sample-tick divider, NUM_UNITS
// oscillator units and the output mixer register.
//   ctl_clk   : control clock, rising edge
//   ctl_rst   : synchronous reset, active-low
//   freq_in   : packed per-unit frequencies, FREQ_WIDTH bits each (Hz)
//   wave_type : packed per-unit waveform codes, 2 bits each
//   aud_freq  : sample rate select, 0 = 48 kHz, 1 = 44.1 kHz
//   wave_out  : signed Q(BITWIDTH-FIXED_POINT).FIXED_POINT mixed sample,
//               updated once per sample tick
module synth
    import synth_pkg::*;
#(
    parameter int BITWIDTH    = 24,
    parameter int FIXED_POINT = 8,
    parameter int NUM_UNITS   = 4,
    parameter int FREQ_WIDTH  = 16,
    parameter int CLK_FREQ    = 100000000
) (
    input  logic                            ctl_clk,
    input  logic                            ctl_rst,
    input  logic [FREQ_WIDTH*NUM_UNITS-1:0] freq_in,
    input  logic [2*NUM_UNITS-1:0]          wave_type,
    input  logic                            aud_freq,
    output logic signed [BITWIDTH-1:0]      wave_out
);

    localparam int SW = FIXED_POINT + 2;

    // Terminal counts derived from the clock; 2082 / 2266 at 100 MHz.
    localparam logic [CNT_W-1:0] DIV48_M1 = CNT_W'(CLK_FREQ / 48000 - 1);
    localparam logic [CNT_W-1:0] DIV44_M1 = CNT_W'(CLK_FREQ / 44100 - 1);

    logic [CNT_W-1:0]           cnt_q;
    logic [CNT_W-1:0]           cnt_d;
    logic [CNT_W-1:0]           div_m1;
    logic                       tick;
    logic [K_W-1:0]             k;
    logic signed [SW-1:0]       samples [NUM_UNITS];
    logic signed [BITWIDTH-1:0] wave_q;
    logic signed [BITWIDTH-1:0] wave_d;
    logic signed [BITWIDTH-1:0] mix;

    assign div_m1 = aud_freq ? DIV44_M1 : DIV48_M1;
    assign k      = aud_freq ? K_44K1 : K_48K;

    // >= rather than == so a rate switch mid-period cannot overshoot.
    assign tick  = (cnt_q >= div_m1);
    assign cnt_d = tick ? '0 : (cnt_q + CNT_W'(1));

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
        synth_osc #(
            .FIXED_POINT (FIXED_POINT),
            .FREQ_WIDTH  (FREQ_WIDTH)
        ) u_osc (
            .clk       (ctl_clk),
            .rst       (ctl_rst),
            .tick      (tick),
            .freq      (freq_in[FREQ_WIDTH*i +: FREQ_WIDTH]),
            .k         (k),
            .wave_type (wave_type[2*i +: 2]),
            .sample    (samples[i])
        );
    end

    // Signed casts sign-extend each unit; the legal-parameter rule
    // guarantees the sum cannot overflow BITWIDTH.
    always_comb begin
        mix = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            mix = mix + BITWIDTH'(samples[i]);
        end
    end

    // Samples come from pre-update phases, so the output lags one sample.
    assign wave_d = tick ? mix : wave_q;

    always_ff @(posedge ctl_clk) begin
        if (!ctl_rst) begin
            cnt_q  <= '0;
            wave_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave_out = wave_q;

endmodule

// File: tb/tb_synth.sv
// Scoreboard bench for the tone generator: a golden cycle model pushes the
// expected wave_out on every reset or sample tick; a monitor pops and
// compares on the falling edge, and checks the output holds between ticks.
module tb_synth;

    logic               ctl_clk = 1'b0;
    logic               ctl_rst = 1'b0;
    logic [63:0]        freq_in = '0;
    logic [7:0]         wave_type = '0;
    logic               aud_freq = 1'b0;
    logic signed [23:0] wave_out;

    int tests = 0;
    int fails = 0;

    int          q_exp[$];
    int          exp_cur = 0;
    bit          started = 0;
    bit          range_chk = 0;
    int          model_ticks = 0;
    int          m_cnt = 0;
    logic [31:0] m_ph [4];

    always #5 ctl_clk = ~ctl_clk;

    synth dut (
        .ctl_clk   (ctl_clk),
        .ctl_rst   (ctl_rst),
        .freq_in   (freq_in),
        .wave_type (wave_type),
        .aud_freq  (aud_freq),
        .wave_out  (wave_out)
    );

    function automatic int unit_val(logic [31:0] ph, logic [1:0] t);
        int p;
        p = int'(ph[31:23]);
        case (t)
            2'd0:    return ph[31] ? -256 : 256;
            2'd1:    return p - 256;
            2'd2:    return (p < 256) ? (2 * p - 256) : (767 - 2 * p);
            default: return 0;
        endcase
    endfunction

    // Golden model, evaluated at each rising edge with the inputs the DUT sees.
    always @(posedge ctl_clk) begin
        int      div;
        int      s;
        longint  kk;
        longint  prod;
        if (!ctl_rst) begin
            m_cnt = 0;
            for (int i = 0; i < 4; i++) m_ph[i] = 32'd0;
            q_exp.push_back(0);
            started = 1;
        end else begin
            div = aud_freq ? 2267 : 2083;
            kk  = aud_freq ? 64'd97392 : 64'd89478;
            if (m_cnt >= div - 1) begin
                s = 0;
                for (int i = 0; i < 4; i++) s += unit_val(m_ph[i], wave_type[2*i +: 2]);
                q_exp.push_back(s);
                for (int i = 0; i < 4; i++) begin
                    prod    = longint'(freq_in[16*i +: 16]) * kk;
                    m_ph[i] = m_ph[i] + prod[31:0];
                end
                m_cnt = 0;
                model_ticks++;
            end else begin
                m_cnt++;
            end
        end
    end

    // Monitor: compare on the falling edge, away from the active edge.
    always @(negedge ctl_clk) begin
        logic signed [23:0] e;
        if (started) begin
            if (q_exp.size() > 0) begin
                exp_cur = q_exp.pop_front();
                e = exp_cur[23:0];
                tests++;
                if (wave_out !== e) begin
                    fails++;
                    $display("FAIL sample t=%0t got=%0d exp=%0d", $time, wave_out, e);
                end
            end else begin
                e = exp_cur[23:0];
                tests++;
                if (wave_out !== e) begin
                    fails++;
                    $display("FAIL hold t=%0t got=%0d exp=%0d", $time, wave_out, e);
                end
            end
            if (range_chk) begin
                tests++;
                if (wave_out < -24'sd1024 || wave_out > 24'sd1023) begin
                    fails++;
                    $display("FAIL range t=%0t got=%0d exp=[-1024,1023]", $time, wave_out);
                end
            end
        end
    end

    task automatic set_units(input int f0, input int f1, input int f2, input int f3,
                             input int t0, input int t1, input int t2, input int t3);
        freq_in   = {f3[15:0], f2[15:0], f1[15:0], f0[15:0]};
        wave_type = {t3[1:0], t2[1:0], t1[1:0], t0[1:0]};
    endtask

    task automatic wait_ticks(input int n);
        int start;
        int budget;
        for (int j = 0; j < n; j++) begin
            start  = model_ticks;
            budget = 3000;
            while (model_ticks == start && budget > 0) begin
                @(negedge ctl_clk);
                budget--;
            end
            if (budget == 0) begin
                tests++;
                fails++;
                $display("FAIL tick_timeout got=none exp=tick within 3000 cycles");
            end
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge ctl_clk);
        ctl_rst = 1'b0;
        repeat (n) @(negedge ctl_clk);
        ctl_rst = 1'b1;
    endtask

    initial begin
        // Reset held 15 cycles, all units square at 0 Hz: 4 x +256 = 1024.
        set_units(0, 0, 0, 0, 0, 0, 0, 0);
        aud_freq = 1'b0;
        repeat (15) @(negedge ctl_clk);
        ctl_rst = 1'b1;
        wait_ticks(3);

        // Square on unit 0, 220 Hz then a fast 12 kHz that flips every ~2 ticks.
        set_units(220, 0, 0, 0, 0, 3, 3, 3);
        wait_ticks(3);
        set_units(12000, 0, 0, 0, 0, 3, 3, 3);
        wait_ticks(5);

        // Sawtooth 440 Hz from reset: starts at -256.
        do_reset(1);
        set_units(440, 0, 0, 0, 1, 3, 3, 3);
        wait_ticks(3);

        // Triangle at 0 Hz: frozen at -256.
        do_reset(1);
        set_units(0, 0, 0, 0, 2, 3, 3, 3);
        wait_ticks(2);

        // Mixed units with a one-edge reset in the middle.
        do_reset(1);
        set_units(220, 440, 880, 1760, 2, 1, 0, 0);
        range_chk = 1;
        wait_ticks(5);
        do_reset(1);
        wait_ticks(4);
        range_chk = 0;

        // 44.1 kHz with maximum frequencies (increment wraps past 2^32).
        set_units(65535, 65535, 65535, 65535, 0, 1, 2, 0);
        aud_freq = 1'b1;
        wait_ticks(5);
        // Switch back to 48 kHz late in a period: next tick comes early.
        repeat (2200) @(negedge ctl_clk);
        aud_freq = 1'b0;
        wait_ticks(2);

        repeat (3) @(negedge ctl_clk);
        tests++;
        if (q_exp.size() != 0) begin
            fails++;
            $display("FAIL queue_drain got=%0d exp=0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
